// File: rtl/prf_mp.sv
// Multi-port physical register file with per-register ready bits and an
// arbitrated read-broadcast path onto a registered CDB.
// Latency: writes and ready updates land at the next edge. A read request
//   accepted at edge E0 can broadcast at E1 at the earliest (two edges).
// Backpressure: each channel holds one request. req_ready drops while that
//   request waits for its register or loses arbitration.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   shared_cdb_*         lowest-priority write source (CDB loopback)
//   wb_ena/wb_id/wb_val  NUM_WB packed writeback ports; a higher index wins
//   alloc_*, retire_*    clear the ready bit of one register each
//   req_valid/req_id     read requests, one per channel
//   req_ready            the channel's holding buffer can take a request
//   ready_regs           registered per-register ready bits
//   cdb_*                registered broadcast of granted reads
module prf_mp #(
    parameter int PRF_SIZE = 16,
    parameter int DATA_W   = 8,
    parameter int NUM_WB   = 2,
    parameter int NUM_REQ  = 2,
    localparam int ID_W    = $clog2(PRF_SIZE),
    localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     shared_cdb_transmit,
    input  logic [ID_W-1:0]          shared_cdb_id,
    input  logic [DATA_W-1:0]        shared_cdb_val,
    input  logic [NUM_WB-1:0]        wb_ena,
    input  logic [NUM_WB*ID_W-1:0]   wb_id,
    input  logic [NUM_WB*DATA_W-1:0] wb_val,
    input  logic                     alloc_ena,
    input  logic [ID_W-1:0]          alloc_id,
    input  logic                     retire_ena,
    input  logic [ID_W-1:0]          retire_id,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*ID_W-1:0]  req_id,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [PRF_SIZE-1:0]      ready_regs,
    output logic                     cdb_transmit,
    output logic [ID_W-1:0]          cdb_id,
    output logic [DATA_W-1:0]        cdb_val,
    output logic [SRC_W-1:0]         cdb_src
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   rf_q     [PRF_SIZE];
    logic [PRF_SIZE-1:0] ready_q, ready_d;

    logic [NUM_REQ-1:0]  buf_vld_q, buf_vld_d;
    logic [ID_W-1:0]     buf_id_q [NUM_REQ];
    logic [ID_W-1:0]     buf_id_d [NUM_REQ];

    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic                cdb_vld_q, cdb_vld_d;
    logic [ID_W-1:0]     cdb_id_q, cdb_id_d;
    logic [DATA_W-1:0]   cdb_val_q, cdb_val_d;
    logic [SRC_W-1:0]    cdb_src_q, cdb_src_d;

    // ------------------------------------------------------------------
    // Write merge: per-register hit and winning data for this cycle.
    // Sources are applied lowest priority first so later ones overwrite.
    // ------------------------------------------------------------------
    logic [PRF_SIZE-1:0] wr_hit;
    logic [DATA_W-1:0]   wr_dat [PRF_SIZE];

    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < PRF_SIZE; i++) begin
            wr_dat[i] = '0;
        end
        if (shared_cdb_transmit) begin
            wr_hit[shared_cdb_id] = 1'b1;
            wr_dat[shared_cdb_id] = shared_cdb_val;
        end
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_ena[k]) begin
                wr_hit[wb_id[k*ID_W +: ID_W]] = 1'b1;
                wr_dat[wb_id[k*ID_W +: ID_W]] = wb_val[k*DATA_W +: DATA_W];
            end
        end
    end

    // Clears first, then sets, so a same-cycle write keeps the bit set.
    always_comb begin
        ready_d = ready_q;
        if (alloc_ena) begin
            ready_d[alloc_id] = 1'b0;
        end
        if (retire_ena) begin
            ready_d[retire_id] = 1'b0;
        end
        ready_d = ready_d | wr_hit;
    end

    // ------------------------------------------------------------------
    // Eligibility uses the pre-update ready bits plus same-cycle writes,
    // so an alloc clearing the bit this cycle does not block the grant.
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] elig;

    always_comb begin
        for (int c = 0; c < NUM_REQ; c++) begin
            elig[c] = buf_vld_q[c] &&
                      (ready_q[buf_id_q[c]] || wr_hit[buf_id_q[c]]);
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter: first eligible channel at or after rr_ptr.
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] grant;
    logic               gnt_any;
    int                 gnt_idx;
    int                 scan_idx;

    always_comb begin
        grant    = '0;
        gnt_any  = 1'b0;
        gnt_idx  = 0;
        scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!gnt_any && elig[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                gnt_idx         = scan_idx;
                gnt_any         = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = SRC_W'((gnt_idx + 1) % NUM_REQ);
        end
    end

    // A granted buffer frees up in the same cycle, so it can reload at once.
    always_comb begin
        for (int c = 0; c < NUM_REQ; c++) begin
            req_ready[c] = !rst && (!buf_vld_q[c] || grant[c]);
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_REQ; c++) begin
            buf_vld_d[c] = buf_vld_q[c];
            buf_id_d[c]  = buf_id_q[c];
            if (req_valid[c] && req_ready[c]) begin
                buf_vld_d[c] = 1'b1;
                buf_id_d[c]  = req_id[c*ID_W +: ID_W];
            end else if (grant[c]) begin
                buf_vld_d[c] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Broadcast: bypass same-cycle write data so a write racing a grant
    // delivers the new value. All fields are zero when nothing is granted.
    // ------------------------------------------------------------------
    logic [ID_W-1:0] gnt_id;

    always_comb begin
        gnt_id    = buf_id_q[gnt_idx];
        cdb_vld_d = 1'b0;
        cdb_id_d  = '0;
        cdb_val_d = '0;
        cdb_src_d = '0;
        if (gnt_any) begin
            cdb_vld_d = 1'b1;
            cdb_id_d  = gnt_id;
            cdb_val_d = wr_hit[gnt_id] ? wr_dat[gnt_id] : rf_q[gnt_id];
            cdb_src_d = SRC_W'(gnt_idx);
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PRF_SIZE; i++) begin
                rf_q[i] <= '0;
            end
            ready_q   <= '0;
            buf_vld_q <= '0;
            for (int c = 0; c < NUM_REQ; c++) begin
                buf_id_q[c] <= '0;
            end
            rr_ptr_q  <= '0;
            cdb_vld_q <= 1'b0;
            cdb_id_q  <= '0;
            cdb_val_q <= '0;
            cdb_src_q <= '0;
        end else begin
            for (int i = 0; i < PRF_SIZE; i++) begin
                if (wr_hit[i]) begin
                    rf_q[i] <= wr_dat[i];
                end
            end
            ready_q   <= ready_d;
            buf_vld_q <= buf_vld_d;
            for (int c = 0; c < NUM_REQ; c++) begin
                buf_id_q[c] <= buf_id_d[c];
            end
            rr_ptr_q  <= rr_ptr_d;
            cdb_vld_q <= cdb_vld_d;
            cdb_id_q  <= cdb_id_d;
            cdb_val_q <= cdb_val_d;
            cdb_src_q <= cdb_src_d;
        end
    end

    assign ready_regs   = ready_q;
    assign cdb_transmit = cdb_vld_q;
    assign cdb_id       = cdb_id_q;
    assign cdb_val      = cdb_val_q;
    assign cdb_src      = cdb_src_q;

endmodule

// File: tb/tb_prf_mp.sv
// Directed bench for prf_mp with default parameters (16 regs, 8-bit data,
// 2 writeback ports, 2 request channels). Inputs change 1 ns after a rising
// edge; outputs are sampled at that same point, away from the edge.
module tb_prf_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        shared_cdb_transmit;
    logic [3:0]  shared_cdb_id;
    logic [7:0]  shared_cdb_val;
    logic [1:0]  wb_ena;
    logic [7:0]  wb_id;
    logic [15:0] wb_val;
    logic        alloc_ena;
    logic [3:0]  alloc_id;
    logic        retire_ena;
    logic [3:0]  retire_id;
    logic [1:0]  req_valid;
    logic [7:0]  req_id;
    logic [1:0]  req_ready;
    logic [15:0] ready_regs;
    logic        cdb_transmit;
    logic [3:0]  cdb_id;
    logic [7:0]  cdb_val;
    logic [0:0]  cdb_src;

    int n_cmp = 0;
    int n_err = 0;

    prf_mp dut (
        .clk                 (clk),
        .rst                 (rst),
        .shared_cdb_transmit (shared_cdb_transmit),
        .shared_cdb_id       (shared_cdb_id),
        .shared_cdb_val      (shared_cdb_val),
        .wb_ena              (wb_ena),
        .wb_id               (wb_id),
        .wb_val              (wb_val),
        .alloc_ena           (alloc_ena),
        .alloc_id            (alloc_id),
        .retire_ena          (retire_ena),
        .retire_id           (retire_id),
        .req_valid           (req_valid),
        .req_id              (req_id),
        .req_ready           (req_ready),
        .ready_regs          (ready_regs),
        .cdb_transmit        (cdb_transmit),
        .cdb_id              (cdb_id),
        .cdb_val             (cdb_val),
        .cdb_src             (cdb_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cdb(input string tag, input logic vld, input logic [3:0] id,
                           input logic [7:0] val, input logic src);
        chk({tag, ".transmit"}, 32'(cdb_transmit), 32'(vld));
        chk({tag, ".id"},       32'(cdb_id),       32'(id));
        chk({tag, ".val"},      32'(cdb_val),      32'(val));
        chk({tag, ".src"},      32'(cdb_src),      32'(src));
    endtask

    task automatic idle();
        shared_cdb_transmit = 1'b0;
        shared_cdb_id       = '0;
        shared_cdb_val      = '0;
        wb_ena              = '0;
        wb_id               = '0;
        wb_val              = '0;
        alloc_ena           = 1'b0;
        alloc_id            = '0;
        retire_ena          = 1'b0;
        retire_id           = '0;
        req_valid           = '0;
        req_id              = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_req_ready_low", 32'(req_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'h3);
        chk("post_rst_ready_regs", 32'(ready_regs), 32'h0);
        chk_cdb("post_rst_cdb", 1'b0, 4'd0, 8'h00, 1'b0);

        // ---------------- wb0 writes 3=A5 ----------------
        wb_ena = 2'b01; wb_id = {4'd0, 4'd3}; wb_val = {8'h00, 8'hA5};
        tick();
        idle();
        chk("wb_ready3", 32'(ready_regs), 32'h0008);
        chk_cdb("wb_no_cdb", 1'b0, 4'd0, 8'h00, 1'b0);
        // read 3 back on channel 0
        req_valid = 2'b01; req_id = {4'd0, 4'd3};
        tick();
        idle();
        chk("rd3_e0_idle", 32'(cdb_transmit), 32'h0);
        tick();
        chk_cdb("rd3_e1", 1'b1, 4'd3, 8'hA5, 1'b0);        // rr_ptr -> 1

        // ---------------- same-id collision on 5 with alloc ----------------
        shared_cdb_transmit = 1'b1; shared_cdb_id = 4'd5; shared_cdb_val = 8'h11;
        wb_ena = 2'b11; wb_id = {4'd5, 4'd5}; wb_val = {8'h33, 8'h22};
        alloc_ena = 1'b1; alloc_id = 4'd5;
        tick();
        idle();
        chk("collide_ready", 32'(ready_regs), 32'h0028);
        chk("rd3_one_cycle", 32'(cdb_transmit), 32'h0);
        req_valid = 2'b01; req_id = {4'd0, 4'd5};
        tick();
        idle();
        tick();
        chk_cdb("collide_rd5", 1'b1, 4'd5, 8'h33, 1'b0);   // rr_ptr stays 1

        // ---------------- channel 1 reads 4=7E ----------------
        wb_ena = 2'b10; wb_id = {4'd4, 4'd0}; wb_val = {8'h7E, 8'h00};
        tick();
        idle();
        req_valid = 2'b10; req_id = {4'd4, 4'd0};
        tick();
        idle();
        chk("ch1_e0_idle", 32'(cdb_transmit), 32'h0);
        tick();
        chk_cdb("ch1_rd4", 1'b1, 4'd4, 8'h7E, 1'b1);       // rr_ptr -> 0
        tick();
        chk("ch1_one_cycle", 32'(cdb_transmit), 32'h0);

        // ---------------- round robin with same-cycle reload ----------------
        wb_ena = 2'b11; wb_id = {4'd6, 4'd2}; wb_val = {8'h66, 8'h12};
        tick();
        idle();
        chk("rr_ready", 32'(ready_regs), 32'h007C);
        req_valid = 2'b11; req_id = {4'd6, 4'd2};
        tick();
        chk("rr_req_ready_g0", 32'(req_ready), 32'h1);
        req_valid = 2'b01; req_id = {4'd0, 4'd3};
        tick();
        idle();
        chk_cdb("rr_first", 1'b1, 4'd2, 8'h12, 1'b0);
        chk("rr_req_ready_g1", 32'(req_ready), 32'h2);
        tick();
        chk_cdb("rr_second", 1'b1, 4'd6, 8'h66, 1'b1);
        tick();
        chk_cdb("rr_third", 1'b1, 4'd3, 8'hA5, 1'b0);
        tick();
        chk("rr_drained", 32'(cdb_transmit), 32'h0);       // rr_ptr = 1

        // ---------------- wait on unready 9, then bypass ----------------
        req_valid = 2'b01; req_id = {4'd0, 4'd9};
        tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            chk("wait9_quiet", 32'(cdb_transmit), 32'h0);
            tick();
        end
        chk("wait9_req_ready", 32'(req_ready), 32'h2);
        wb_ena = 2'b01; wb_id = {4'd0, 4'd9}; wb_val = {8'h00, 8'h40};
        tick();
        idle();
        chk_cdb("bypass9", 1'b1, 4'd9, 8'h40, 1'b0);       // rr_ptr -> 1
        chk("bypass9_ready", 32'(ready_regs), 32'h027C);

        // ---------------- alloc racing a grant on 2 ----------------
        req_valid = 2'b10; req_id = {4'd2, 4'd0};
        tick();
        idle();
        alloc_ena = 1'b1; alloc_id = 4'd2;
        tick();
        idle();
        chk_cdb("alloc_race", 1'b1, 4'd2, 8'h12, 1'b1);
        chk("alloc_clears2", 32'(ready_regs), 32'h0278);

        // ---------------- retire 3 and retire 6 with a write to 6 ----------------
        retire_ena = 1'b1; retire_id = 4'd3;
        tick();
        idle();
        chk("retire3", 32'(ready_regs), 32'h0270);
        retire_ena = 1'b1; retire_id = 4'd6;
        wb_ena = 2'b01; wb_id = {4'd0, 4'd6}; wb_val = {8'h00, 8'h67};
        tick();
        idle();
        chk("retire6_set_wins", 32'(ready_regs), 32'h0270);

        // ---------------- reset drops buffered requests ----------------
        req_valid = 2'b11; req_id = {4'd12, 4'd11};
        tick();
        idle();
        chk("held_req_ready", 32'(req_ready), 32'h0);
        rst = 1'b1;
        req_valid = 2'b11; req_id = {4'd13, 4'd13};
        tick();
        idle();
        rst = 1'b0;
        #1;
        chk("rst2_req_ready", 32'(req_ready), 32'h3);
        chk("rst2_ready_regs", 32'(ready_regs), 32'h0);
        chk("rst2_cdb", 32'(cdb_transmit), 32'h0);
        shared_cdb_transmit = 1'b1; shared_cdb_id = 4'd13; shared_cdb_val = 8'h0D;
        wb_ena = 2'b11; wb_id = {4'd12, 4'd11}; wb_val = {8'h0C, 8'h0B};
        tick();
        idle();
        chk("rst2_no_bcast_a", 32'(cdb_transmit), 32'h0);
        chk("rst2_ready_after_wr", 32'(ready_regs), 32'h3800);
        tick();
        chk("rst2_no_bcast_b", 32'(cdb_transmit), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prf_mp.md
# prf_mp

Parametrised multi-port physical register file with per-register ready tracking and an arbitrated read-broadcast path. It is the next-generation physical register file of the out-of-order core. It accepts NUM_WB writeback ports plus the shared CDB loopback, and clears ready bits on rename allocation and on retirement. Read requests from NUM_REQ consumers are buffered, held until the source register is ready, round-robin arbitrated, and broadcast on a registered CDB output.

## Interface
Parameters:
- PRF_SIZE, 16, number of physical registers; ID_W = $clog2(PRF_SIZE)
- DATA_W, 8, register data width
- NUM_WB, 2, writeback ports
- NUM_REQ, 2, read-request channels; SRC_W = max(1, $clog2(NUM_REQ))

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; one clock, synchronous, active-high
- shared_cdb_transmit  in  1  shared CDB loopback valid
- shared_cdb_id  in  ID_W  loopback register id
- shared_cdb_val  in  DATA_W  loopback data
- wb_ena  in  NUM_WB  per-port write enable
- wb_id  in  NUM_WB*ID_W  packed write ids; port k at [k*ID_W +: ID_W]
- wb_val  in  NUM_WB*DATA_W  packed write data
- alloc_ena  in  1  rename allocated a register; clear its ready bit
- alloc_id  in  ID_W  allocated id
- retire_ena  in  1  old mapping retired; clear its ready bit
- retire_id  in  ID_W  retired id
- req_valid  in  NUM_REQ  read request per channel
- req_id  in  NUM_REQ*ID_W  packed requested ids
- req_ready  out  NUM_REQ  channel can accept a request this cycle
- ready_regs  out  PRF_SIZE  per-register ready bit (registered)
- cdb_transmit  out  1  broadcast valid (registered)
- cdb_id  out  ID_W  broadcast id
- cdb_val  out  DATA_W  broadcast data
- cdb_src  out  SRC_W  channel that originated the broadcast

## Operation
- Write sources in ascending priority: shared CDB, then wb port 0 … NUM_WB-1. When several sources target the same id in one cycle, the highest-priority source's data is stored.
- Ready update per cycle: alloc and retire clears apply first. Any write (shared CDB or wb) then sets the bit. A set wins over a clear on the same id in the same cycle.
- Each channel has a one-entry holding buffer (valid, id).
  - A request is accepted when req_valid[c] && req_ready[c].
  - req_ready[c] = !rst && (!buf_valid[c] || grant[c]), so a new request can be accepted in the same cycle the buffered one is granted.
- Eligibility: a buffer entry is eligible when ready_regs[id] is set, or when a write to that id occurs in the current cycle.
- Arbiter: round-robin over eligible entries, starting at rr_ptr. At most one grant per cycle. On grant, rr_ptr becomes the granted index + 1, modulo NUM_REQ. With no grant, rr_ptr holds.
- Grant data is the bypassed value: the highest-priority same-cycle write to that id if present, otherwise rf[id].
- Entries whose register is never written stay buffered indefinitely. No timeout.
- When there is no grant, cdb_transmit, cdb_id, cdb_val and cdb_src are all 0.

## Timing
- Reset: rf, ready_regs, buffers, rr_ptr and all cdb_* outputs go to 0. req_ready is 0 while rst is high. In-flight buffered requests are dropped, and a request presented during reset is not accepted.
- Writes and ready updates are visible on ready_regs and in rf the cycle after the edge.
- Request latency:
  - Accept at edge E0; buffer is valid in the following cycle.
  - If the entry is eligible and granted in that cycle, the cdb_* outputs are registered at edge E1. Minimum latency is 2 edges.
- Throughput: one broadcast per cycle total. One request per channel per cycle when that channel is granted every cycle.
- A write and a grant to the same id in the same cycle: the broadcast carries the new value.
- Alloc to the same id as an eligible buffered entry with no write that cycle: eligibility uses the pre-update ready_regs, so the entry may still be granted that cycle.

## Test plan
- Reset, then wb_ena=01, wb_id[0]=3, wb_val[0]=0xA5 -> next cycle ready_regs[3]=1 and rf[3]=0xA5. All cdb_* outputs remain 0.
- Same-id collision: shared CDB writes id 5=0x11, wb0 writes 5=0x22, wb1 writes 5=0x33, plus alloc_ena on id 5, all in one cycle -> rf[5]=0x33 and ready_regs[5]=1.
- Register 4 ready with value 0x7E; channel 1 requests id 4 -> two edges later cdb_transmit=1, cdb_id=4, cdb_val=0x7E, cdb_src=1 for exactly one cycle.
- Both channels hold requests to ready ids 2 and 6 with rr_ptr=0 -> channel 0 broadcasts first, channel 1 the next cycle. A new channel-0 request accepted in the first grant cycle is broadcast third.
- Request id 9 while ready_regs[9]=0 -> no broadcast for 5 cycles. Then wb writes 9=0x40 -> broadcast of 0x40 registered at that same edge, via bypass.
- Assert rst with two buffered requests -> no broadcast follows. After reset, req_ready=all-ones and ready_regs=0.
